// File: rtl/tdm_demultiplexer.sv
// Receive side of a TDM link: locks to SYNC, collects CHANNELS beats per frame and
// presents the whole frame on Q with a one-cycle Q_VALID. Define TDM_DEMULTIPLEXER_STATS_EN
// to add a FRAMES completion counter.
module tdm_demultiplexer #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned WIDTH    = 8,
    localparam int unsigned SW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      CLOCK,
    input  logic                      RESET,
    input  logic [WIDTH-1:0]          D,
    input  logic                      D_VALID,
    input  logic                      SYNC,
    input  logic                      ERR_CLR,
    output logic [CHANNELS*WIDTH-1:0] Q,
    output logic                      Q_VALID,
    output logic                      LOCK,
    output logic [SW-1:0]             SLOT,
`ifdef TDM_DEMULTIPLEXER_STATS_EN
    output logic [15:0]               FRAMES,
`endif
    output logic                      ERR
);

    typedef enum logic [0:0] {StHunt, StLocked} state_e;

    localparam logic [SW-1:0] LastSlot = SW'(CHANNELS - 1);

    state_e                      state_q, state_d;
    logic [SW-1:0]               slot_q, slot_d;
    logic [WIDTH-1:0]            shadow_q [CHANNELS];
    logic [WIDTH-1:0]            shadow_d [CHANNELS];
    logic [CHANNELS*WIDTH-1:0]   q_q, q_d;
    logic                        q_valid_q, q_valid_d;
    logic                        err_q, err_d;

    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        shadow_d  = shadow_q;
        q_d       = q_q;
        q_valid_d = 1'b0;
        err_d     = err_q & ~ERR_CLR;

        if (D_VALID) begin
            unique case (state_q)
                StHunt: begin
                    if (SYNC) begin
                        shadow_d[0] = D;
                        slot_d      = SW'(1);
                        state_d     = StLocked;
                    end
                end
                StLocked: begin
                    if (SYNC) begin
                        // An early SYNC drops the partial frame and restarts at slot 0.
                        if (slot_q != '0) begin
                            err_d = 1'b1;
                        end
                        shadow_d[0] = D;
                        slot_d      = SW'(1);
                    end else if (slot_q == '0) begin
                        err_d   = 1'b1;
                        slot_d  = '0;
                        state_d = StHunt;
                    end else begin
                        shadow_d[slot_q] = D;
                        if (slot_q == LastSlot) begin
                            for (int k = 0; k < int'(CHANNELS) - 1; k++) begin
                                q_d[k*WIDTH +: WIDTH] = shadow_q[k];
                            end
                            q_d[(CHANNELS-1)*WIDTH +: WIDTH] = D;
                            q_valid_d = 1'b1;
                            slot_d    = '0;
                        end else begin
                            slot_d = slot_q + SW'(1);
                        end
                    end
                end
                default: state_d = StHunt;
            endcase
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q   <= StHunt;
            slot_q    <= '0;
            q_q       <= '0;
            q_valid_q <= 1'b0;
            err_q     <= 1'b0;
            for (int k = 0; k < int'(CHANNELS); k++) begin
                shadow_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
            err_q     <= err_d;
            for (int k = 0; k < int'(CHANNELS); k++) begin
                shadow_q[k] <= shadow_d[k];
            end
        end
    end

`ifdef TDM_DEMULTIPLEXER_STATS_EN
    logic [15:0] frames_q, frames_d;

    // A completion on the clearing edge still counts, leaving FRAMES at 1.
    always_comb begin
        frames_d = ERR_CLR ? 16'd0 : frames_q;
        if (q_valid_d) begin
            frames_d = frames_d + 16'd1;
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            frames_q <= 16'd0;
        end else begin
            frames_q <= frames_d;
        end
    end

    assign FRAMES = frames_q;
`endif

    assign Q       = q_q;
    assign Q_VALID = q_valid_q;
    assign LOCK    = (state_q == StLocked);
    assign SLOT    = slot_q;
    assign ERR     = err_q;

endmodule

// File: tb/tb_tdm_demultiplexer.sv
// Self-checking bench for tdm_demultiplexer: directed frames plus random beats,
// compared against a queue-based frame model.
module tb_tdm_demultiplexer;

    localparam int CH = 4;
    localparam int W  = 8;

    logic          CLOCK = 1'b0;
    logic          RESET;
    logic [W-1:0]  D;
    logic          D_VALID;
    logic          SYNC;
    logic          ERR_CLR;
    logic [CH*W-1:0] Q;
    logic          Q_VALID;
    logic          LOCK;
    logic [1:0]    SLOT;
    logic          ERR;
`ifdef TDM_DEMULTIPLEXER_STATS_EN
    logic [15:0]   FRAMES;
`endif

    tdm_demultiplexer #(
        .CHANNELS(CH),
        .WIDTH   (W)
    ) dut (
        .CLOCK  (CLOCK),
        .RESET  (RESET),
        .D      (D),
        .D_VALID(D_VALID),
        .SYNC   (SYNC),
        .ERR_CLR(ERR_CLR),
        .Q      (Q),
        .Q_VALID(Q_VALID),
        .LOCK   (LOCK),
        .SLOT   (SLOT),
`ifdef TDM_DEMULTIPLEXER_STATS_EN
        .FRAMES (FRAMES),
`endif
        .ERR    (ERR)
    );

    always #5 CLOCK = ~CLOCK;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: beats of the frame in progress, empty when slot 0 is next.
    logic [W-1:0]    frame[$];
    bit              m_locked;
    bit              m_err;
    logic [CH*W-1:0] m_q;
    bit              m_qv;
    logic [15:0]     m_frames;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".q"},      64'(Q),       64'(m_q));
        check_eq({tag, ".qvalid"}, 64'(Q_VALID), 64'(m_qv));
        check_eq({tag, ".lock"},   64'(LOCK),    64'(m_locked));
        check_eq({tag, ".slot"},   64'(SLOT),    64'(frame.size()));
        check_eq({tag, ".err"},    64'(ERR),     64'(m_err));
`ifdef TDM_DEMULTIPLEXER_STATS_EN
        check_eq({tag, ".frames"}, 64'(FRAMES),  64'(m_frames));
`endif
    endtask

    task automatic model_reset();
        frame.delete();
        m_locked = 0;
        m_err    = 0;
        m_q      = '0;
        m_qv     = 0;
        m_frames = '0;
    endtask

    task automatic step(input string tag, input bit v, input bit s, input logic [W-1:0] d,
                        input bit clr);
        bit new_err;
        @(negedge CLOCK);
        D_VALID = v;
        SYNC    = s;
        D       = d;
        ERR_CLR = clr;
        @(posedge CLOCK);
        new_err = 0;
        m_qv    = 0;
        if (v) begin
            if (!m_locked) begin
                if (s) begin
                    frame    = {d};
                    m_locked = 1;
                end
            end else if (s) begin
                if (frame.size() != 0) new_err = 1;
                frame = {d};
            end else if (frame.size() == 0) begin
                new_err  = 1;
                m_locked = 0;
            end else begin
                frame.push_back(d);
                if (frame.size() == CH) begin
                    for (int k = 0; k < CH; k++) m_q[k*W +: W] = frame[k];
                    m_qv = 1;
                    frame.delete();
                end
            end
        end
        m_err = (m_err && !clr) || new_err;
        if (clr) m_frames = '0;
        if (m_qv) m_frames = m_frames + 16'd1;
        #1;
        check_all(tag);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step("gap", 0, $urandom_range(0, 1), 8'($urandom), 0);
    endtask

    task automatic frame4(input string tag, input logic [W-1:0] base);
        step(tag, 1, 1, base, 0);
        for (int k = 1; k < CH; k++) step(tag, 1, 0, base + 8'(k), 0);
    endtask

    initial begin
        RESET   = 1'b1;
        D       = '0;
        D_VALID = 1'b0;
        SYNC    = 1'b0;
        ERR_CLR = 1'b0;
        model_reset();
        repeat (2) @(posedge CLOCK);
        #1;
        check_all("reset");
        @(negedge CLOCK);
        RESET = 1'b0;

        // Unsynced beats are ignored.
        step("t1", 1, 0, 8'h11, 0);
        step("t1", 1, 0, 8'h22, 0);
        step("t1", 1, 0, 8'h33, 0);

        // Full-rate frame.
        frame4("t2", 8'hA0);
        check_eq("t2.frame", 64'(Q), 64'h00000000_A3A2A1A0);
        step("t2.after", 0, 0, 8'h00, 0);

        // Same frame with D_VALID gaps.
        for (int k = 0; k < CH; k++) begin
            step("t3", 1, (k == 0), 8'hA0 + 8'(k), 0);
            idle($urandom_range(1, 3));
        end

        // Early sync discards the partial B frame.
        step("t4", 1, 1, 8'hB0, 0);
        step("t4", 1, 0, 8'hB1, 0);
        frame4("t4", 8'hC0);
        check_eq("t4.frame", 64'(Q), 64'h00000000_C3C2C1C0);
        step("t4.clr", 0, 0, 8'h00, 1);
        check_eq("t4.errclr", 64'(ERR), 64'd0);

        // Missing sync at slot 0 drops lock.
        step("t5", 1, 0, 8'hD0, 0);
        check_eq("t5.unlock", 64'(LOCK), 64'd0);
        frame4("t5", 8'hE0);
        check_eq("t5.frame", 64'(Q), 64'h00000000_E3E2E1E0);

        // Error and clear on the same edge: the error wins.
        step("errwin", 1, 1, 8'h10, 0);
        step("errwin", 1, 1, 8'h20, 1);
        check_eq("errwin.err", 64'(ERR), 64'd1);
        step("errwin.clr", 0, 0, 8'h00, 1);

        // Five frames, then reset mid-frame.
        for (int f = 0; f < 5; f++) frame4("t6.pre", 8'h40 + 8'(f * 16));
        step("t6", 1, 1, 8'h50, 0);
        step("t6", 1, 0, 8'h51, 0);
        #1;
        RESET = 1'b1;
        #1;
        model_reset();
        check_all("t6.rst");
        @(negedge CLOCK);
        RESET = 1'b0;
        step("t6.tail", 1, 0, 8'h52, 0);
        step("t6.tail", 1, 0, 8'h53, 0);

        // Random traffic, mostly well-formed with injected framing faults.
        for (int i = 0; i < 1500; i++) begin
            bit v, s, clr;
            v   = ($urandom_range(0, 99) < 75);
            s   = (frame.size() == 0) ? ($urandom_range(0, 99) < 85)
                                      : ($urandom_range(0, 99) < 6);
            clr = ($urandom_range(0, 99) < 4);
            step("rand", v, s, 8'($urandom), clr);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/tdm_demultiplexer.md
Name: tdm_demultiplexer

Overview:
- Receive end of a time-division multiplexed link. The transmit side interleaves CHANNELS samples per frame onto one shared bus and flags slot 0 with SYNC.
- This block locks to SYNC and routes each accepted beat to its channel slot.
- It presents a complete, registered frame of all channels with a one-cycle valid pulse.
- It sits between the shared link bus and per-channel consumers.

Parameters:
- CHANNELS, 4, number of slots per frame (>=2).
- WIDTH, 8, bits per sample/beat.

Ports:
- CLOCK  input  1  system clock; all state updates on the rising edge.
- RESET  input  1  asynchronous, active-high reset.
- D  input  WIDTH  link data beat.
- D_VALID  input  1  beat qualifier; D and SYNC are sampled only when 1.
- SYNC  input  1  marks the current beat as slot 0.
- ERR_CLR  input  1  clears ERR.
- Q  output  CHANNELS*WIDTH  frame output; channel k at Q[k*WIDTH +: WIDTH].
- Q_VALID  output  1  one-cycle pulse when Q is updated.
- LOCK  output  1  high while in LOCKED.
- SLOT  output  $clog2(CHANNELS)  index of the next expected slot.
- ERR  output  1  sticky framing-error flag.

Behaviour:
- Reset (async, RESET=1): state=HUNT; Q=0; Q_VALID=0; LOCK=0; SLOT=0; ERR=0; shadow registers=0. Deassertion is sampled on the next CLOCK edge.
- Beat definition: a beat is any rising edge with D_VALID=1. Edges with D_VALID=0 change nothing except the Q_VALID clear and ERR_CLR.
- HUNT state:
  - Beats with SYNC=0 are discarded.
  - A beat with SYNC=1: D goes to shadow[0], SLOT<=1, state<=LOCKED.
- LOCKED state, on each beat:
  - SYNC=0 and SLOT!=0: D goes to shadow[SLOT].
    - If SLOT==CHANNELS-1: Q<={D, shadow[CHANNELS-2..0]}, Q_VALID<=1, SLOT<=0.
    - Otherwise: SLOT<=SLOT+1.
  - SYNC=1 and SLOT==0: D goes to shadow[0], SLOT<=1. This is a normal frame start.
  - SYNC=1 and SLOT!=0 (early sync): ERR<=1, the partial frame is discarded, the beat is taken as the new slot 0 (shadow[0]<=D, SLOT<=1), and the block stays LOCKED.
  - SYNC=0 and SLOT==0 (missing sync): ERR<=1, the beat is discarded, state<=HUNT, SLOT<=0.
- Latency: Q and Q_VALID are registered. They are visible the cycle after the edge that samples the last-slot beat.
- Q_VALID is high for exactly one cycle per completed frame. Q holds its value until the next completed frame.
- Back-to-back frames at full rate (D_VALID=1 every cycle): one Q_VALID every CHANNELS cycles.
- ERR: cleared by ERR_CLR=1 at an edge. If a new error and ERR_CLR occur on the same edge, the error wins and ERR stays 1.
- LOCK is the registered state (1 in LOCKED). SLOT is held through D_VALID gaps.
- RESET mid-frame: partial frame is lost, Q returns to 0, and the next frame requires SYNC.
- No frame ever mixes beats from two frames.

Optional Feature:
- Macro: TDM_DEMULTIPLEXER_STATS_EN.
- Defined: adds output FRAMES [15:0].
  - Reset to 0.
  - Increments on every edge that sets Q_VALID; wraps 0xFFFF->0x0000.
  - Cleared together with ERR by ERR_CLR. If ERR_CLR coincides with a frame completion, FRAMES=1.
- Undefined: no FRAMES port and no counter logic; all other behaviour is identical.

Test Plan (CHANNELS=4, WIDTH=8):
1. After reset, beats 0x11, 0x22, 0x33 with SYNC=0 -> LOCK=0, Q_VALID never pulses, Q=0x00000000, ERR=0.
2. Consecutive beats 0xA0(SYNC=1), 0xA1, 0xA2, 0xA3 -> LOCK=1 after the first edge; the cycle after the 0xA3 edge, Q=0xA3A2A1A0 and Q_VALID=1 for one cycle; SLOT=0.
3. Same frame as test 2 with D_VALID=0 gaps of 1–3 cycles between beats -> identical Q and one Q_VALID pulse; SLOT holds during the gaps.
4. Locked, beats 0xB0(SYNC=1), 0xB1, then 0xC0(SYNC=1), 0xC1, 0xC2, 0xC3 -> ERR=1 at the 0xC0 edge, Q unchanged, no pulse for the B frame; afterwards Q=0xC3C2C1C0 with one Q_VALID; ERR_CLR then clears ERR.
5. Locked at slot 0, a beat 0xD0 with SYNC=0 -> ERR=1, LOCK=0, SLOT=0. Next beats 0xE0(SYNC=1), 0xE1, 0xE2, 0xE3 -> Q=0xE3E2E1E0.
6. RESET pulsed after two beats of a frame (with TDM_DEMULTIPLEXER_STATS_EN and FRAMES=5) -> Q=0, LOCK=0, ERR=0, FRAMES=0 immediately; the remaining two beats with SYNC=0 produce no Q_VALID.
